// File: rtl/dac_arb_pkg.sv
// Shared types and constants for the VCTCXO tuning-DAC arbiter.
package dac_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_GAP
    } dac_state_e;

    localparam int         FRAME_W  = 24;
    localparam logic [3:0] CMD_DFLT = 4'b0011;  // write and update
    localparam logic [3:0] ADDR_NIB = 4'b1111;  // all DACs

    // Slot index inside a frame: 0 is setup, 1..48 are sclk half-periods,
    // 49 is the hold after the last falling edge.
    localparam logic [5:0] SLOT_LAST_HALF = 6'd48;
    localparam logic [5:0] SLOT_HOLD      = 6'd49;

    // Keep the top 'bits' bits of a 16-bit code, force the rest to zero.
    function automatic logic [15:0] dac_mask(input logic [15:0] code, input int bits);
        logic [15:0] m;
        m = '0;
        for (int i = 0; i < 16; i++) begin
            m[i] = (i >= 16 - bits);
        end
        return code & m;
    endfunction

endpackage

// File: rtl/dac_spi_shift.sv
// 24-bit SPI serializer for the tuning DAC. A frame is 50 slots of CLK_DIV
// cycles each: setup, 48 sclk half-periods, hold. Pins are registered so
// they never glitch and go idle immediately on reset.
module dac_spi_shift
    import dac_arb_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [FRAME_W-1:0] frame,
    output logic               setup_end,
    output logic               shift_end,
    output logic               done,
    output logic               sclk,
    output logic               mosi,
    output logic               sync_n
);

    localparam int            TW       = $clog2(CLK_DIV + 1);
    localparam logic [TW-1:0] TMR_LOAD = TW'(CLK_DIV - 1);

    logic               active;
    logic [TW-1:0]      tmr;
    logic [5:0]         slot;
    logic [5:0]         slot_nxt;
    logic [FRAME_W-1:0] shreg;
    logic               slot_tc;

    assign slot_tc   = active && (tmr == '0);
    assign slot_nxt  = slot + 6'd1;
    assign setup_end = slot_tc && (slot == 6'd0);
    assign shift_end = slot_tc && (slot == SLOT_LAST_HALF);
    assign done      = slot_tc && (slot == SLOT_HOLD);

    // Slot timer, bit shifter and pin registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active <= 1'b0;
            tmr    <= '0;
            slot   <= '0;
            shreg  <= '0;
            sclk   <= 1'b0;
            mosi   <= 1'b0;
            sync_n <= 1'b1;
        end else if (start && !active) begin
            active <= 1'b1;
            tmr    <= TMR_LOAD;
            slot   <= '0;
            shreg  <= frame;
            sclk   <= 1'b0;
            mosi   <= frame[FRAME_W-1];
            sync_n <= 1'b0;
        end else if (slot_tc) begin
            tmr <= TMR_LOAD;
            if (slot == SLOT_HOLD) begin
                active <= 1'b0;
                sclk   <= 1'b0;
                mosi   <= 1'b0;
                sync_n <= 1'b1;
            end else begin
                slot <= slot_nxt;
                // odd slots are the sclk-high halves
                sclk <= slot_nxt[0] && (slot_nxt < SLOT_LAST_HALF);
                // entering a low half is a falling edge: present the next bit
                if (!slot_nxt[0] && (slot_nxt <= SLOT_LAST_HALF)) begin
                    shreg <= {shreg[FRAME_W-2:0], 1'b0};
                    mosi  <= shreg[FRAME_W-2];
                end
            end
        end else if (active) begin
            tmr <= tmr - 1'b1;
        end
    end

endmodule

// File: rtl/vctcxo_dac_arbiter.sv
// VCTCXO tuning-DAC arbiter: power-up write, host and loop request slots,
// fixed priority init > host > loop, inter-frame gap and status.
//
// state    | meaning
// ---------+-------------------------------------------------
// ST_IDLE  | no frame; grants the highest-priority request
// ST_SETUP | sync_n low, sclk low, first bit on mosi
// ST_SHIFT | 24 bits clocked out MSB first
// ST_HOLD  | settle after the last falling edge
// ST_GAP   | sync_n high for MIN_GAP cycles
module vctcxo_dac_arbiter
    import dac_arb_pkg::*;
#(
    parameter int         CLK_DIV  = 4,
    parameter int         MIN_GAP  = 16,
    parameter int         DAC_BITS = 12,
    parameter logic [3:0] CMD      = CMD_DFLT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] dac_dflt,
    input  logic [15:0] loop_dat,
    input  logic        loop_stb,
    input  logic [15:0] host_dat,
    input  logic        host_vld,
    output logic        host_rdy,
    input  logic        host_ovr,
    output logic        busy,
    output logic [15:0] last_dat,
    output logic [7:0]  coal_cnt,
    output logic        sclk,
    output logic        mosi,
    output logic        sync_n
);

    localparam int            GW       = $clog2(MIN_GAP + 1);
    localparam logic [GW-1:0] GAP_LOAD = GW'(MIN_GAP - 1);

    dac_state_e state_q, state_d;

    logic          started;
    logic          init_pend, host_pend, loop_pend;
    logic [15:0]   init_dat, host_buf, loop_buf;
    logic          ovr_q;
    logic [15:0]   cur_dat;
    logic [GW-1:0] gap_tmr;

    logic          grant_init, grant_host, grant_loop, grant_any;
    logic [15:0]   sel_dat;
    logic [15:0]   sel_masked;
    logic          coal_inc;
    logic          setup_end, shift_end, frame_done;

    assign host_rdy   = !host_pend;
    assign busy       = (state_q != ST_IDLE);
    assign grant_any  = grant_init || grant_host || grant_loop;
    assign sel_masked = dac_mask(sel_dat, DAC_BITS);
    assign coal_inc   = loop_stb && (host_ovr || (loop_pend && !grant_loop));

    // Fixed-priority grant and word select; the loop is locked out under override.
    always_comb begin
        grant_init = 1'b0;
        grant_host = 1'b0;
        grant_loop = 1'b0;
        sel_dat    = loop_buf;
        if (state_q == ST_IDLE && started) begin
            if (init_pend) begin
                grant_init = 1'b1;
                sel_dat    = init_dat;
            end else if (host_pend) begin
                grant_host = 1'b1;
                sel_dat    = host_buf;
            end else if (loop_pend && !host_ovr) begin
                grant_loop = 1'b1;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (grant_any)        state_d = ST_SETUP;
            ST_SETUP: if (setup_end)        state_d = ST_SHIFT;
            ST_SHIFT: if (shift_end)        state_d = ST_HOLD;
            ST_HOLD:  if (frame_done)       state_d = ST_GAP;
            ST_GAP:   if (gap_tmr == '0)    state_d = ST_IDLE;
            default:                        state_d = ST_IDLE;
        endcase
    end

    // State register and gap down-counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            gap_tmr <= '0;
        end else begin
            state_q <= state_d;
            if (frame_done) begin
                gap_tmr <= GAP_LOAD;
            end else if (state_q == ST_GAP && gap_tmr != '0) begin
                gap_tmr <= gap_tmr - 1'b1;
            end
        end
    end

    // Power-up request: dac_dflt is captured on the first cycle out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            started   <= 1'b0;
            init_pend <= 1'b0;
            init_dat  <= '0;
        end else if (!started) begin
            started   <= 1'b1;
            init_pend <= 1'b1;
            init_dat  <= dac_dflt;
        end else if (grant_init) begin
            init_pend <= 1'b0;
        end
    end

    // Host slot: one-deep, refilled by the valid/ready handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            host_pend <= 1'b0;
            host_buf  <= '0;
        end else if (host_vld && !host_pend) begin
            host_pend <= 1'b1;
            host_buf  <= host_dat;
        end else if (grant_host) begin
            host_pend <= 1'b0;
        end
    end

    // Loop slot: newest value wins; override rising edge flushes it silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            loop_pend <= 1'b0;
            loop_buf  <= '0;
            ovr_q     <= 1'b0;
        end else begin
            ovr_q <= host_ovr;
            if (host_ovr && !ovr_q) begin
                loop_pend <= 1'b0;
            end else if (grant_loop) begin
                loop_pend <= 1'b0;
            end
            if (loop_stb && !host_ovr) begin
                loop_pend <= 1'b1;
                loop_buf  <= loop_dat;
            end
        end
    end

    // Status: saturating coalesce count and the code of the last finished frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coal_cnt <= '0;
            cur_dat  <= '0;
            last_dat <= '0;
        end else begin
            if (coal_inc && coal_cnt != 8'hFF) begin
                coal_cnt <= coal_cnt + 8'd1;
            end
            if (grant_any) begin
                cur_dat <= sel_masked;
            end
            if (frame_done) begin
                last_dat <= cur_dat;
            end
        end
    end

    dac_spi_shift #(
        .CLK_DIV (CLK_DIV)
    ) u_shift (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (grant_any),
        .frame     ({CMD, ADDR_NIB, sel_masked}),
        .setup_end (setup_end),
        .shift_end (shift_end),
        .done      (frame_done),
        .sclk      (sclk),
        .mosi      (mosi),
        .sync_n    (sync_n)
    );

endmodule

// File: tb/tb_vctcxo_dac_arbiter.sv
// Bench for the VCTCXO DAC arbiter: transaction-level reference model with a
// per-cycle compare, a pin monitor that reassembles frames, directed scenarios
// with literal expectations, and a randomized phase.
module tb_vctcxo_dac_arbiter;

    localparam int CD        = 4;
    localparam int MG        = 16;
    localparam int DB        = 12;
    localparam int FRAME_CYC = 50 * CD;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] dac_dflt = 16'h8000;
    logic [15:0] loop_dat = '0;
    logic        loop_stb = 1'b0;
    logic [15:0] host_dat = '0;
    logic        host_vld = 1'b0;
    logic        host_ovr = 1'b0;
    logic        host_rdy, busy, sclk, mosi, sync_n;
    logic [15:0] last_dat;
    logic [7:0]  coal_cnt;

    always #5 clk = ~clk;

    vctcxo_dac_arbiter dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .dac_dflt (dac_dflt),
        .loop_dat (loop_dat),
        .loop_stb (loop_stb),
        .host_dat (host_dat),
        .host_vld (host_vld),
        .host_rdy (host_rdy),
        .host_ovr (host_ovr),
        .busy     (busy),
        .last_dat (last_dat),
        .coal_cnt (coal_cnt),
        .sclk     (sclk),
        .mosi     (mosi),
        .sync_n   (sync_n)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_bound(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    // ---------------- reference model (transaction level) ----------------
    int          e_cnt = 0, g = -100000, next_free = 1, last_at = -1, coal = 0;
    logic        init_p = 0, host_p = 0, loop_p = 0, ovr_prev = 0;
    logic [15:0] init_v = 0, host_v = 0, loop_v = 0, last_v = 0, pend_last = 0;
    logic [23:0] fw = 0;
    logic        exp_busy = 0, exp_sclk = 0, exp_mosi = 0, exp_sync = 1;
    logic        m_hp, m_lp, m_gr, m_gl;
    logic [15:0] m_w;

    function automatic logic [15:0] code_of(input logic [15:0] v);
        return (v >> (16 - DB)) << (16 - DB);
    endfunction

    task automatic model_reset();
        e_cnt = 0; g = -100000; next_free = 1; last_at = -1; coal = 0;
        init_p = 0; host_p = 0; loop_p = 0; ovr_prev = 0;
        last_v = 0;
        exp_busy = 0; exp_sclk = 0; exp_mosi = 0; exp_sync = 1;
    endtask

    // Advance the model one clock using the inputs seen at this edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_reset();
        end else begin
            int d, s;
            if (e_cnt == last_at) last_v = pend_last;
            m_hp = host_p; m_lp = loop_p; m_gr = 0; m_gl = 0; m_w = 0;
            if (e_cnt >= next_free) begin
                if (init_p) begin m_gr = 1; m_w = init_v; init_p = 0; end
                else if (host_p) begin m_gr = 1; m_w = host_v; host_p = 0; end
                else if (loop_p && !host_ovr) begin m_gr = 1; m_gl = 1; m_w = loop_v; loop_p = 0; end
            end
            if (e_cnt == 0) begin init_p = 1; init_v = dac_dflt; end
            if (host_vld && !m_hp) begin host_p = 1; host_v = host_dat; end
            if (host_ovr && !ovr_prev) loop_p = 0;
            if (loop_stb) begin
                if (host_ovr) begin
                    if (coal < 255) coal++;
                end else begin
                    if (m_lp && !m_gl && coal < 255) coal++;
                    loop_p = 1; loop_v = loop_dat;
                end
            end
            ovr_prev = host_ovr;
            if (m_gr) begin
                g = e_cnt;
                pend_last = code_of(m_w);
                fw = {4'h3, 4'hF, pend_last};
                last_at = e_cnt + FRAME_CYC;
                next_free = e_cnt + FRAME_CYC + MG + 1;
            end
            d = e_cnt - g;
            s = d / CD;
            exp_busy = (d >= 0) && (d < FRAME_CYC + MG);
            if (d >= 0 && d < FRAME_CYC) begin
                exp_sync = 0;
                exp_sclk = (s >= 1) && (s <= 47) && (s % 2 == 1);
                exp_mosi = (s / 2 < 24) ? fw[23 - s / 2] : 1'b0;
            end else begin
                exp_sync = 1; exp_sclk = 0; exp_mosi = 0;
            end
            e_cnt++;
        end
    end

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        chk("busy",     {31'd0, busy},     {31'd0, exp_busy});
        chk("host_rdy", {31'd0, host_rdy}, {31'd0, !host_p});
        chk("last_dat", {16'd0, last_dat}, {16'd0, last_v});
        chk("coal_cnt", {24'd0, coal_cnt}, coal);
        chk("sync_n",   {31'd0, sync_n},   {31'd0, exp_sync});
        chk("sclk",     {31'd0, sclk},     {31'd0, exp_sclk});
        chk("mosi",     {31'd0, mosi},     {31'd0, exp_mosi});
    end

    // ---------------- pin monitor ----------------
    logic [23:0] mon_word = 0;
    int          mon_low = 0, mon_high = 0, cur_gap = 0;
    logic        mon_seen = 0, prev_sclk = 0, prev_sync = 1;
    logic [23:0] fq_word[$];
    int          fq_low[$];
    int          fq_gap[$];

    always @(negedge clk) begin
        if (!rst_n) begin
            mon_word = 0; mon_low = 0; mon_high = 0; cur_gap = 0;
            mon_seen = 0; prev_sclk = 0; prev_sync = 1;
        end else begin
            if (!sync_n && prev_sync) begin
                cur_gap = mon_seen ? mon_high : 0;
                mon_low = 0; mon_word = 0;
            end
            if (!sync_n) begin
                mon_low++;
                if (sclk && !prev_sclk) mon_word = {mon_word[22:0], mosi};
            end
            if (sync_n && !prev_sync) begin
                fq_word.push_back(mon_word);
                fq_low.push_back(mon_low);
                fq_gap.push_back(cur_gap);
                mon_seen = 1; mon_high = 0;
            end
            if (sync_n) mon_high++;
            prev_sclk = sclk; prev_sync = sync_n;
        end
    end

    // ---------------- stimulus helpers (called at negedge) ----------------
    task automatic host_write(input logic [15:0] v);
        int n = 0;
        while (!host_rdy && n < 3000) begin @(negedge clk); n++; end
        if (!host_rdy) fail_bound("host_rdy_wait");
        host_dat = v; host_vld = 1'b1;
        @(negedge clk);
        host_vld = 1'b0;
    endtask

    task automatic loop_strobe(input logic [15:0] v);
        loop_dat = v; loop_stb = 1'b1;
        @(negedge clk);
        loop_stb = 1'b0;
    endtask

    task automatic wait_sync_low();
        int n = 0;
        while (sync_n && n < 1000) begin @(negedge clk); n++; end
        if (sync_n) fail_bound("sync_low_wait");
    endtask

    task automatic wait_quiet();
        int n = 0, q = 0;
        while (q < 4 && n < 3000) begin
            @(negedge clk); n++;
            if (!busy && host_rdy) q++; else q = 0;
        end
        if (q < 4) fail_bound("quiet_wait");
    endtask

    task automatic wait_frames(input int cnt);
        int n = 0;
        while (fq_word.size() < cnt && n < 3000) begin @(negedge clk); n++; end
        if (fq_word.size() < cnt) fail_bound("frame_wait");
    endtask

    task automatic pop_frame(input string name, input logic [23:0] exp_w, output int low, output int gap);
        low = 0; gap = 0;
        if (fq_word.size() == 0) begin
            fail_bound({name, "_missing"});
        end else begin
            chk(name, {8'd0, fq_word.pop_front()}, {8'd0, exp_w});
            low = fq_low.pop_front();
            gap = fq_gap.pop_front();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        int low, gap;
        int nfr;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_sync_n",   {31'd0, sync_n},   32'd1);
        chk("rst_sclk",     {31'd0, sclk},     32'd0);
        chk("rst_busy",     {31'd0, busy},     32'd0);
        chk("rst_host_rdy", {31'd0, host_rdy}, 32'd1);
        chk("rst_coal",     {24'd0, coal_cnt}, 32'd0);
        rst_n = 1'b1;

        // power-up frame, host write arrives during it
        repeat (20) @(negedge clk);
        host_write(16'h1234);
        chk("host_rdy_held", {31'd0, host_rdy}, 32'd0);
        wait_frames(2);
        pop_frame("init_frame", 24'h3F8000, low, gap);
        chk("init_low", low, 32'd200);
        pop_frame("host_frame", 24'h3F1230, low, gap);
        chk("host_low", low, 32'd200);
        chk("init_gap_min", {31'd0, gap >= MG}, 32'd1);
        wait_quiet();
        chk("last_dat_host", {16'd0, last_dat}, 32'h1230);

        // three loop strobes during one frame coalesce to the last
        host_write(16'hAAAA);
        wait_sync_low();
        repeat (20) @(negedge clk);
        loop_strobe(16'h1000);
        repeat (30) @(negedge clk);
        loop_strobe(16'h2000);
        repeat (30) @(negedge clk);
        loop_strobe(16'h3000);
        wait_quiet();
        pop_frame("coal_host", 24'h3FAAA0, low, gap);
        pop_frame("coal_loop", 24'h3F3000, low, gap);
        chk("coal_two", {24'd0, coal_cnt}, 32'd2);
        chk("coal_extra_frames", fq_word.size(), 32'd0);

        // override window: loop discarded, host still served
        host_ovr = 1'b1;
        for (int i = 0; i < 10; i++) begin
            loop_strobe(16'h4000 + 16'(i));
            if (i == 4) host_write(16'h7777);
            repeat (99) @(negedge clk);
        end
        host_ovr = 1'b0;
        wait_quiet();
        chk("ovr_frames", fq_word.size(), 32'd1);
        pop_frame("ovr_host", 24'h3F7770, low, gap);
        chk("ovr_coal", {24'd0, coal_cnt}, 32'd12);

        // host and loop both pending at IDLE: host first, then loop
        host_write(16'h1111);
        wait_sync_low();
        repeat (10) @(negedge clk);
        host_write(16'h5555);
        loop_strobe(16'h6666);
        wait_quiet();
        pop_frame("both_first", 24'h3F1110, low, gap);
        pop_frame("both_host", 24'h3F5550, low, gap);
        pop_frame("both_loop", 24'h3F6660, low, gap);
        chk("both_gap_min", {31'd0, gap >= MG}, 32'd1);
        chk("both_coal", {24'd0, coal_cnt}, 32'd12);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            loop_dat = 16'($urandom);
            loop_stb = ($urandom_range(3) == 0);
            host_dat = 16'($urandom);
            host_vld = ($urandom_range(9) == 0);
            if ($urandom_range(199) == 0) host_ovr = ~host_ovr;
            @(negedge clk);
        end
        loop_stb = 1'b0; host_vld = 1'b0; host_ovr = 1'b0;
        wait_quiet();
        chk("coal_saturated", {24'd0, coal_cnt}, 32'd255);
        nfr = fq_word.size();
        fq_word.delete(); fq_low.delete(); fq_gap.delete();
        if (nfr == 0) fail_bound("random_no_frames");

        // async reset in the middle of SHIFT
        host_write(16'h2222);
        wait_sync_low();
        repeat (100) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_sync_n", {31'd0, sync_n}, 32'd1);
        chk("abort_sclk",   {31'd0, sclk},   32'd0);
        chk("abort_busy",   {31'd0, busy},   32'd0);
        dac_dflt = 16'hBEEF;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_frames(1);
        pop_frame("restart_frame", 24'h3FBEE0, low, gap);
        chk("restart_low", low, 32'd200);
        wait_quiet();
        chk("restart_last", {16'd0, last_dat}, 32'hBEE0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vctcxo_dac_arbiter.md
Name: vctcxo_dac_arbiter

Overview:
- Owns the serial VCTCXO tuning DAC (LTC2630-class, 24-bit write frames) and arbitrates writes from two requesters: the PPS disciplining loop (strobed value) and host software (valid/ready).
- Issues a one-time power-up write of a default code, coalesces loop updates, enforces a minimum inter-frame gap, and supports a host override that locks out the loop.
- Sits between the ppsloop control output and the DAC pins, in the 200 MHz loop clock domain.

Parameters:
- CLK_DIV, 4, clk cycles per SCLK half-period (>=2).
- MIN_GAP, 16, clk cycles with sync_n high between frames (>=1).
- DAC_BITS, 12, significant DAC bits; data[15:16-DAC_BITS] are sent MSB-aligned, lower bits forced to 0.
- CMD, 4'b0011, frame command nibble (write and update).

Ports:
- clk  in  1  loop clock (200 MHz).
- rst_n  in  1  asynchronous, active-low reset.
- dac_dflt  in  16  power-up code; sampled when leaving reset.
- loop_dat  in  16  loop DAC value.
- loop_stb  in  1  one-cycle strobe; loop_dat valid.
- host_dat  in  16  host DAC value.
- host_vld  in  1  host request valid.
- host_rdy  out  1  host slot empty; transfer occurs on vld&rdy.
- host_ovr  in  1  level; 1 = loop writes discarded.
- busy  out  1  frame or gap in progress.
- last_dat  out  16  code of the most recently completed frame.
- coal_cnt  out  8  saturating count of overwritten or discarded loop values.
- sclk, mosi, sync_n  out  1 each  DAC serial pins.

Behaviour:
- Reset values: sync_n=1, sclk=0, mosi=0, busy=0, host_rdy=1, last_dat=0, coal_cnt=0, all pending flags clear. Async assert aborts any frame immediately; the pins go idle the same instant.
- First cycle after reset release: the internal init request is loaded with dac_dflt and takes priority over all other requests. host_rdy=1 throughout.
- Loop slot: loop_stb captures loop_dat and sets loop_pend.
  - Strobe while loop_pend=1: value overwritten, coal_cnt+1.
  - Strobe while host_ovr=1: discarded, coal_cnt+1.
  - host_ovr rising clears any loop_pend without counting it.
  - Strobe in the same cycle that arbitration consumes the slot: the new value becomes pending; not counted.
- Host slot: the vld&rdy handshake captures host_dat and drops host_rdy. host_rdy returns to 1 the cycle after arbitration consumes the slot.
- Arbitration in IDLE, fixed priority init > host > loop. A grant latches the word and moves to SETUP the next cycle.
- FSM:
  - IDLE: waits for a request.
  - SETUP: sync_n=0, sclk=0, mosi=frame[23], held for CLK_DIV cycles.
  - SHIFT: 24 bits MSB-first; sclk high CLK_DIV cycles, then low CLK_DIV cycles. mosi updates on sclk falling, so the DAC samples on rising.
  - HOLD: CLK_DIV cycles after the 24th falling edge; sync_n=1 at exit; last_dat updates at exit.
  - GAP: MIN_GAP cycles, then IDLE.
- Frame = {CMD, 4'b1111, data masked per DAC_BITS}.
- Frame timing: sync_n low for exactly 50*CLK_DIV cycles (200 at default). busy=1 from the SETUP entry cycle through the last GAP cycle.
- coal_cnt saturates at 255 and never wraps.
- last_dat reports the masked code.

Decomposition:
- Shared package dac_arb_pkg holds: state enum (IDLE, SETUP, SHIFT, HOLD, GAP), frame width 24, default CMD, address nibble, and a function for masking by DAC_BITS.
- One sub-module, dac_spi_shift: a 24-bit serializer with start/done and the CLK_DIV timer. The arbiter owns the slots, priority, gap and status.

Test Plan:
- Reset release with dac_dflt=16'h8000:
  - First frame mosi sequence = 24'h3F8000.
  - sync_n low 200 cycles.
  - last_dat=16'h8000.
  - Gap of 16 cycles before the next frame.
- Host write 16'h1234 during the init frame:
  - host_rdy=0 until the init frame's GAP ends.
  - Next frame = 24'h3F1230 (low nibble masked).
- Three loop strobes (0x1000, 0x2000, 0x3000) during one frame:
  - Only 0x3000 is sent next.
  - coal_cnt=2.
- host_ovr=1 with loop strobes every 100 cycles for 1000 cycles: no loop frames, coal_cnt=10. A host write during this window is still sent.
- Host and loop both pending at IDLE: host frame first, then loop frame, with the MIN_GAP gap between them.
- rst_n low midway through SHIFT:
  - sync_n=1, sclk=0 asynchronously.
  - After release, the dac_dflt frame restarts from bit 23.
